// File: rtl/link_pkg.sv
// Shared definitions for the 1-wire token link: frame constants and
// receiver state encoding, common to the transmitter and rx_token_buffer.
package link_pkg;

  localparam int   TOKEN_W   = 55;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_token_shift.sv
// Link deserializer: start-bit detection, LSB-first data capture and stop-bit
// check. Emits a one-cycle push with the complete token on a good stop bit.
module rx_token_shift
  import link_pkg::*;
#(
  parameter int DATA_W = TOKEN_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_data_i,
  output logic              push_o,
  output logic [DATA_W-1:0] token_o,
  output logic              frame_err_o
);

  localparam int                BIT_CW   = $clog2(DATA_W);
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;

  // State register, bit counter, shift register and registered error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic; the push is combinational so the FIFO writes on the
  // same edge that samples the stop bit.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_o      = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (s_data_i == START_BIT) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        shift_d[bit_cnt_q] = s_data_i;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = RX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end
      RX_STOP: begin
        // A bad stop bit returns to IDLE; it is never reused as a start bit.
        if (s_data_i == STOP_BIT) begin
          push_o = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = RX_IDLE;
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign token_o     = shift_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/rx_token_buffer.sv
// Receiving end of the token link: deserializer feeding a DEPTH-entry register
// FIFO with valid/ready output, overflow flag and saturating drop counter.
module rx_token_buffer
  import link_pkg::*;
#(
  parameter int DATA_W = TOKEN_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              Clk_S,
  input  logic              Rst_n,
  input  logic              S_Data,
  input  logic              RX_Ready,
  output logic              RX_Data_Valid,
  output logic [DATA_W-1:0] RX_Data,
  output logic              Frame_Err,
  output logic              Overflow,
  output logic [CNT_W-1:0]  Drop_Cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              push_s;
  logic [DATA_W-1:0] token_s;
  logic              empty_s, full_s, pop_s, wr_en_s, drop_s;

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  rx_token_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk_i       (Clk_S),
    .rst_ni      (Rst_n),
    .s_data_i    (S_Data),
    .push_o      (push_s),
    .token_o     (token_s),
    .frame_err_o (Frame_Err)
  );

  // The extra pointer MSB distinguishes full from empty when indices match.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_s   = !empty_s && RX_Ready;
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Pointer advance and overflow bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO control registers.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage; on push+pop while full the write lands in the slot being read out.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= token_s;
    end
  end

  assign RX_Data_Valid = !empty_s;
  assign RX_Data       = empty_s ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign Overflow      = overflow_q;
  assign Drop_Cnt      = drop_cnt_q;

endmodule

// File: tb/tb_rx_token_buffer.sv
// Bench for rx_token_buffer: the bench acts as the transmitter and keeps a
// queue-based model of the delivered tokens, overflow flag and drop count.
module tb_rx_token_buffer;

  localparam int DW    = 55;
  localparam int DEPTH = 2;
  localparam int CW    = 8;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          s_data = 1'b0;
  logic          rdy    = 1'b0;
  logic          valid;
  logic [DW-1:0] data;
  logic          ferr;
  logic          ovf;
  logic [CW-1:0] dcnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Transmitter annotations for the bit being driven this cycle.
  bit            push_now = 1'b0;
  bit            err_now  = 1'b0;
  logic [DW-1:0] push_tok = '0;

  // Behavioural model state.
  logic [DW-1:0] mq[$];
  bit            m_ovf  = 1'b0;
  int            m_drop = 0;
  bit            m_ferr = 1'b0;

  always #1 clk = ~clk;

  rx_token_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .Clk_S         (clk),
    .Rst_n         (rst_n),
    .S_Data        (s_data),
    .RX_Ready      (rdy),
    .RX_Data_Valid (valid),
    .RX_Data       (data),
    .Frame_Err     (ferr),
    .Overflow      (ovf),
    .Drop_Cnt      (dcnt)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    m_ferr = 1'b0;
  end

  // Model: a FIFO of at most DEPTH tokens, updated once per rising edge.
  always @(posedge clk) begin
    if (rst_n) begin
      bit pop;
      bit full;
      pop  = (mq.size() > 0) && rdy;
      full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (push_now) begin
        if (!full || pop) mq.push_back(push_tok);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_ferr = err_now;
    end
  end

  // Compare process: every cycle out of reset, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("valid", {63'd0, valid}, {63'd0, mq.size() > 0});
      check("data", {9'd0, data}, (mq.size() > 0) ? {9'd0, mq[0]} : 64'd0);
      check("frame_err", {63'd0, ferr}, {63'd0, m_ferr});
      check("overflow", {63'd0, ovf}, {63'd0, m_ovf});
      check("drop_cnt", {56'd0, dcnt}, 64'(m_drop));
    end
  end

  function automatic logic pick_rdy(input int mode, input bit is_stop);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return is_stop;
    endcase
  endfunction

  task automatic drive_bit(input logic b, input logic r, input bit pn, input bit en);
    s_data   = b;
    rdy      = r;
    push_now = pn;
    err_now  = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) drive_bit(1'b0, pick_rdy(mode, 1'b0), 1'b0, 1'b0);
  endtask

  // mode: 0 ready low, 1 ready high, 2 random, 3 ready only on the stop bit.
  task automatic send_frame(input logic [DW-1:0] tok, input bit good, input int mode);
    push_tok = tok;
    drive_bit(1'b1, pick_rdy(mode, 1'b0), 1'b0, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(tok[i], pick_rdy(mode, 1'b0), 1'b0, 1'b0);
    drive_bit(good ? 1'b0 : 1'b1, pick_rdy(mode, 1'b1), good, !good);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    idle(2, 0);
    rst_n  = 1'b1;
    idle(1, 0);
    chk_en = 1'b1;
  endtask

  localparam logic [DW-1:0] TOK_A = 55'h2DDC71DDC71DDD;
  localparam logic [DW-1:0] TOK_B = 55'h1;
  localparam logic [DW-1:0] TOK_C = 55'h123456789ABCD;

  initial begin
    logic [63:0]   r;
    logic [DW-1:0] t;
    int            start_cnt;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_data", {9'd0, data}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_dcnt", {56'd0, dcnt}, 64'd0);
    rst_n = 1'b1;
    idle(2, 0);
    chk_en = 1'b1;

    // Single token 3: valid rises on the 57th sampled bit, popped next edge.
    push_tok  = 55'd3;
    start_cnt = 0;
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
    start_cnt++;
    for (int i = 0; i < DW; i++) begin
      drive_bit(push_tok[i], 1'b1, 1'b0, 1'b0);
      start_cnt++;
    end
    check("t2_not_early", {63'd0, valid}, 64'd0);
    drive_bit(1'b0, 1'b1, 1'b1, 1'b0);
    start_cnt++;
    check("t2_latency", 64'(start_cnt), 64'd57);
    check("t2_valid", {63'd0, valid}, 64'd1);
    check("t2_data", {9'd0, data}, 64'd3);
    idle(1, 1);
    check("t2_popped", {63'd0, valid}, 64'd0);

    // Back-to-back A,B held with ready low.
    send_frame(TOK_A, 1'b1, 0);
    send_frame(TOK_B, 1'b1, 0);
    idle(3, 0);
    check("t3_head_a", {9'd0, data}, {9'd0, TOK_A});
    idle(1, 1);
    check("t3_head_b", {9'd0, data}, {9'd0, TOK_B});
    idle(1, 1);
    check("t3_empty", {63'd0, valid}, 64'd0);

    // Third token into a full FIFO is dropped.
    send_frame(TOK_A, 1'b1, 0);
    send_frame(TOK_B, 1'b1, 0);
    send_frame(TOK_C, 1'b1, 0);
    check("t4_ovf", {63'd0, ovf}, 64'd1);
    check("t4_dcnt", {56'd0, dcnt}, 64'd1);
    check("t4_head_a", {9'd0, data}, {9'd0, TOK_A});
    idle(1, 1);
    check("t4_head_b", {9'd0, data}, {9'd0, TOK_B});
    idle(1, 1);
    check("t4_no_c", {63'd0, valid}, 64'd0);

    // Reset mid-frame with a token stored: outputs clear asynchronously.
    send_frame(TOK_A, 1'b1, 0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive_bit(TOK_C[i], 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    fork
      wait (valid === 1'b0 && data === '0 && ferr === 1'b0 && ovf === 1'b0 && dcnt === '0);
      @(posedge clk);
    join_any
    disable fork;
    check("t1_async_valid", {63'd0, valid}, 64'd0);
    check("t1_async_data", {9'd0, data}, 64'd0);
    check("t1_async_ovf", {63'd0, ovf}, 64'd0);
    check("t1_async_dcnt", {56'd0, dcnt}, 64'd0);
    check("t1_async_ferr", {63'd0, ferr}, 64'd0);
    @(negedge clk);
    s_data = 1'b0;
    idle(1, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(70, 1);
    check("t1_no_spurious", {63'd0, valid}, 64'd0);

    // Full FIFO with ready on C's stop edge: push+pop accepted.
    send_frame(TOK_A, 1'b1, 0);
    send_frame(TOK_B, 1'b1, 0);
    send_frame(TOK_C, 1'b1, 3);
    check("t5_no_ovf", {63'd0, ovf}, 64'd0);
    check("t5_head_b", {9'd0, data}, {9'd0, TOK_B});
    idle(1, 1);
    check("t5_head_c", {9'd0, data}, {9'd0, TOK_C});
    idle(1, 1);
    check("t5_empty", {63'd0, valid}, 64'd0);

    // Bad stop bit: one-cycle Frame_Err, nothing pushed, next frame fine.
    send_frame(55'h7, 1'b0, 1);
    check("t6_ferr", {63'd0, ferr}, 64'd1);
    check("t6_no_push", {63'd0, valid}, 64'd0);
    idle(1, 1);
    check("t6_ferr_pulse", {63'd0, ferr}, 64'd0);
    send_frame(55'h5, 1'b1, 1);
    check("t6_data5", {9'd0, data}, 64'd5);
    idle(2, 1);

    // Randomised traffic against the model.
    for (int k = 0; k < 40; k++) begin
      r = {$urandom(), $urandom()};
      t = r[DW-1:0];
      send_frame(t, ($urandom_range(0, 99) < 85), 2);
      idle($urandom_range(0, 3), 2);
    end
    idle(4, 1);

    // Drop counter saturation.
    do_reset();
    for (int k = 0; k < 260; k++) begin
      r = {$urandom(), $urandom()};
      t = r[DW-1:0];
      send_frame(t, 1'b1, 0);
    end
    check("sat_dcnt", {56'd0, dcnt}, 64'd255);
    check("sat_ovf", {63'd0, ovf}, 64'd1);
    idle(3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
